// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period helper,
// reused by the receiver and the matching transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } uart_rx_state_e;

   // Whole clock cycles per bit period; any fractional remainder is dropped.
   function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                     input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= RESET_VALUE;
         sync_reg <= RESET_VALUE;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/uart_rx_deser.sv
// UART receiver: 8N1-style deserializer with mid-bit sampling, glitch
// rejection on the start bit, stop-bit error detection and a one-deep output.
module uart_rx_deser
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned BAUD_RATE  = 115200
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  rx_i,
   input  logic                  ready_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  frame_err_o,
   output logic                  overrun_o
);

   localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int TIMER_W = (CLKS_PER_BIT < 4) ? 2 : $clog2(CLKS_PER_BIT);
   localparam int CNT_W   = $clog2(DATA_WIDTH + 1);
   localparam logic [TIMER_W-1:0] HALF_BIT = TIMER_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TIMER_W-1:0] FULL_BIT = TIMER_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   generate
      if (CLKS_PER_BIT < 4) begin : g_bad_baud
         $error("uart_rx_deser: CLK_FREQ/BAUD_RATE must be at least 4");
      end
   endgenerate

   logic rx_sync;

   sync_2ff #(
      .RESET_VALUE(1'b1)
   ) u_sync (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .d     (rx_i),
      .q     (rx_sync)
   );

   uart_rx_state_e        state_reg, state_next;
   logic [TIMER_W-1:0]    timer_reg, timer_next;
   logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
   logic [DATA_WIDTH-1:0] shift_reg, shift_next;
   logic [DATA_WIDTH-1:0] data_reg;
   logic                  valid_reg;
   logic                  frame_err_reg;
   logic                  overrun_reg;
   logic                  frame_done;
   logic                  stop_err;
   logic                  load_out;
   logic                  drop_out;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg   <= IDLE;
         timer_reg   <= '0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         timer_reg   <= timer_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      timer_next   = timer_reg + 1'b1;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      frame_done   = 1'b0;
      stop_err     = 1'b0;
      case (state_reg)
         IDLE: begin
            timer_next = '0;
            if (!rx_sync) state_next = START;
         end
         START: begin
            // Re-check the line at mid start bit; a high here was only a glitch.
            if (timer_reg == HALF_BIT) begin
               timer_next = '0;
               if (rx_sync) begin
                  state_next = IDLE;
               end else begin
                  state_next   = DATA;
                  bit_cnt_next = '0;
               end
            end
         end
         DATA: begin
            if (timer_reg == FULL_BIT) begin
               timer_next   = '0;
               shift_next   = DATA_WIDTH'({rx_sync, shift_reg} >> 1);
               bit_cnt_next = bit_cnt_reg + 1'b1;
               if (bit_cnt_reg == LAST_BIT) state_next = STOP;
            end
         end
         STOP: begin
            if (timer_reg == FULL_BIT) begin
               timer_next = '0;
               if (rx_sync) begin
                  frame_done = 1'b1;
                  state_next = IDLE;
               end else begin
                  stop_err   = 1'b1;
                  state_next = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            // A held-low line (break) must not be mistaken for a new start bit.
            timer_next = '0;
            if (rx_sync) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            timer_next = '0;
         end
      endcase
   end

   assign load_out = frame_done && (!valid_reg || ready_i);
   assign drop_out = frame_done && valid_reg && !ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_reg      <= '0;
         valid_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         frame_err_reg <= stop_err;
         overrun_reg   <= drop_out;
         if (load_out) begin
            data_reg  <= shift_reg;
            valid_reg <= 1'b1;
         end else if (valid_reg && ready_i) begin
            valid_reg <= 1'b0;
         end
      end
   end

   assign valid_o     = valid_reg;
   assign data_o      = data_reg;
   assign frame_err_o = frame_err_reg;
   assign overrun_o   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser at 10 clocks per bit: table of single
// frames, hand-written corner sequences, then randomized frames vs. a queue model.
module tb_uart_rx_deser;

   localparam int CPB = 10;
   localparam int W   = 8;

   typedef struct {
      logic [7:0] data;
      int         stop_low;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_err;
   } vec_t;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       rx_i = 1'b1;
   logic       ready_i = 1'b1;
   logic       valid_o;
   logic [7:0] data_o;
   logic       frame_err_o;
   logic       overrun_o;

   int n_checks = 0;
   int n_errors = 0;
   int n_err_pulses = 0;
   int n_ovr_pulses = 0;
   int n_valid_rise = 0;
   logic valid_prev = 1'b0;
   logic [7:0] acc_q[$];

   always #5 clk_i = ~clk_i;

   uart_rx_deser #(
      .DATA_WIDTH(W),
      .CLK_FREQ  (1_000_000),
      .BAUD_RATE (100_000)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .rx_i        (rx_i),
      .ready_i     (ready_i),
      .valid_o     (valid_o),
      .data_o      (data_o),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o)
   );

   // Observe outputs mid-cycle; valid && ready here means a transfer on the next edge.
   always @(negedge clk_i) begin
      if (frame_err_o) n_err_pulses <= n_err_pulses + 1;
      if (overrun_o) n_ovr_pulses <= n_ovr_pulses + 1;
      if (valid_o && !valid_prev) n_valid_rise <= n_valid_rise + 1;
      valid_prev <= valid_o;
      if (valid_o && ready_i) acc_q.push_back(data_o);
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      rx_i = 1'b1;
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] last_acc();
      if (acc_q.size() == 0) return 8'hxx;
      return acc_q[acc_q.size()-1];
   endfunction

   // Drives one frame on the line; stop_low > 0 holds the line low that many
   // clocks from the start of the stop bit. Optional single-cycle ready pulse
   // in the completion cycle, and optional reset pulse during data bit 4.
   task automatic send_frame(input logic [7:0] d, input int stop_low,
                             input bit rdy_pulse, input bit rst_mid);
      logic [9:0] bits;
      int total;
      bits  = {1'b1, d, 1'b0};
      total = 9 * CPB + stop_low + CPB;
      for (int i = 0; i < total; i++) begin
         if (i < 9 * CPB) rx_i = bits[i / CPB];
         else if (i < 9 * CPB + stop_low) rx_i = 1'b0;
         else rx_i = 1'b1;
         if (rdy_pulse && i == 97) ready_i = 1'b1;
         if (rdy_pulse && i == 98) ready_i = 1'b0;
         if (rst_mid && i == 52) rst_ni = 1'b0;
         if (rst_mid && i == 55) begin
            check("rst_mid valid_o", 32'(valid_o), 32'd0);
            check("rst_mid data_o", 32'(data_o), 32'd0);
            check("rst_mid frame_err_o", 32'(frame_err_o), 32'd0);
            check("rst_mid overrun_o", 32'(overrun_o), 32'd0);
         end
         if (rst_mid && i == 57) rst_ni = 1'b1;
         tick();
      end
   endtask

   vec_t vec[6];
   logic [7:0] exp_q[$];

   initial begin
      int v0, e0, o0, a0, exp_err, base_acc, base_err;
      logic [7:0] d;
      int stop_low, gap;

      vec[0] = '{8'hA5, 0,  1'b1, 8'hA5, 1'b0};
      vec[1] = '{8'h55, 30, 1'b0, 8'h00, 1'b1};
      vec[2] = '{8'h01, 0,  1'b1, 8'h01, 1'b0};
      vec[3] = '{8'h00, 0,  1'b1, 8'h00, 1'b0};
      vec[4] = '{8'hFF, 0,  1'b1, 8'hFF, 1'b0};
      vec[5] = '{8'h80, 12, 1'b0, 8'h00, 1'b1};

      rst_ni = 1'b0;
      rx_i   = 1'b1;
      ready_i = 1'b1;
      tick(); tick(); tick();
      check("reset valid_o", 32'(valid_o), 32'd0);
      check("reset data_o", 32'(data_o), 32'd0);
      check("reset frame_err_o", 32'(frame_err_o), 32'd0);
      check("reset overrun_o", 32'(overrun_o), 32'd0);
      rst_ni = 1'b1;
      idle(5);

      for (int i = 0; i < 6; i++) begin
         v0 = n_valid_rise; e0 = n_err_pulses; o0 = n_ovr_pulses;
         send_frame(vec[i].data, vec[i].stop_low, 1'b0, 1'b0);
         idle(5);
         $display("vec %0d: data=0x%02h stop_low=%0d valid=%0d err=%0d out=0x%02h",
                  i, vec[i].data, vec[i].stop_low, n_valid_rise - v0, n_err_pulses - e0, data_o);
         check("vec valid count", 32'(n_valid_rise - v0), 32'(vec[i].exp_valid));
         if (vec[i].exp_valid) check("vec data", 32'(last_acc()), 32'(vec[i].exp_data));
         check("vec frame_err count", 32'(n_err_pulses - e0), 32'(vec[i].exp_err));
         check("vec overrun count", 32'(n_ovr_pulses - o0), 32'd0);
      end

      // Short low glitch must be rejected, then a real frame still decodes.
      v0 = n_valid_rise; e0 = n_err_pulses;
      rx_i = 1'b0;
      tick(); tick(); tick();
      idle(25);
      $display("glitch: valid=%0d err=%0d", n_valid_rise - v0, n_err_pulses - e0);
      check("glitch no valid", 32'(n_valid_rise - v0), 32'd0);
      check("glitch no frame_err", 32'(n_err_pulses - e0), 32'd0);
      send_frame(8'h3C, 0, 1'b0, 1'b0);
      idle(5);
      $display("after glitch: out=0x%02h", last_acc());
      check("after glitch valid", 32'(n_valid_rise - v0), 32'd1);
      check("after glitch data", 32'(last_acc()), 32'h3C);

      // Overrun: second frame arrives while the first is still unconsumed.
      ready_i = 1'b0;
      a0 = acc_q.size(); o0 = n_ovr_pulses;
      send_frame(8'h11, 0, 1'b0, 1'b0);
      idle(5);
      send_frame(8'h22, 0, 1'b0, 1'b0);
      idle(5);
      $display("overrun: data=0x%02h valid=%0d ovr=%0d", data_o, valid_o, n_ovr_pulses - o0);
      check("overrun data held", 32'(data_o), 32'h11);
      check("overrun valid held", 32'(valid_o), 32'd1);
      check("overrun pulse count", 32'(n_ovr_pulses - o0), 32'd1);
      check("overrun nothing taken", 32'(acc_q.size() - a0), 32'd0);
      ready_i = 1'b1;
      tick(); tick();
      check("overrun drain valid", 32'(valid_o), 32'd0);
      check("overrun drain data", 32'(last_acc()), 32'h11);

      // Consumer accepts pending 0x66 in the very cycle 0x77 completes.
      ready_i = 1'b0;
      send_frame(8'h66, 0, 1'b0, 1'b0);
      idle(5);
      a0 = acc_q.size(); o0 = n_ovr_pulses;
      send_frame(8'h77, 0, 1'b1, 1'b0);
      idle(3);
      $display("same-cycle accept: data=0x%02h valid=%0d taken=0x%02h", data_o, valid_o, last_acc());
      check("same-cycle taken count", 32'(acc_q.size() - a0), 32'd1);
      check("same-cycle taken data", 32'(last_acc()), 32'h66);
      check("same-cycle new data", 32'(data_o), 32'h77);
      check("same-cycle valid", 32'(valid_o), 32'd1);
      check("same-cycle no overrun", 32'(n_ovr_pulses - o0), 32'd0);

      // Reset during data bit 4 abandons both the pending output and the frame.
      v0 = n_valid_rise;
      send_frame(8'hF3, 0, 1'b0, 1'b1);
      idle(10);
      check("post-reset valid", 32'(valid_o), 32'd0);
      check("post-reset no frame", 32'(n_valid_rise - v0), 32'd0);
      ready_i = 1'b1;
      send_frame(8'h9E, 0, 1'b0, 1'b0);
      idle(5);
      $display("post-reset frame: out=0x%02h", last_acc());
      check("post-reset frame count", 32'(n_valid_rise - v0), 32'd1);
      check("post-reset frame data", 32'(last_acc()), 32'h9E);

      // Random frames: good stop -> delivered in order, low stop -> one error pulse.
      base_acc = acc_q.size();
      base_err = n_err_pulses;
      exp_err  = 0;
      exp_q.delete();
      for (int t = 0; t < 24; t++) begin
         d        = 8'($urandom_range(0, 255));
         stop_low = ($urandom_range(0, 4) == 0) ? int'($urandom_range(CPB, 40)) : 0;
         gap      = int'($urandom_range(0, 15));
         if (stop_low == 0) exp_q.push_back(d);
         else exp_err++;
         send_frame(d, stop_low, 1'b0, 1'b0);
         idle(gap);
         $display("rand %0d: data=0x%02h stop_low=%0d gap=%0d", t, d, stop_low, gap);
         check("rand delivered count", 32'(acc_q.size() - base_acc), 32'(exp_q.size()));
         check("rand frame_err count", 32'(n_err_pulses - base_err), 32'(exp_err));
      end
      idle(5);
      for (int k = 0; k < exp_q.size(); k++) begin
         if (base_acc + k < acc_q.size())
            check("rand data order", 32'(acc_q[base_acc + k]), 32'(exp_q[k]));
         else
            check("rand data missing", 32'd0, 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_deser.md
UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving data bits per frame.
REQ-002 SHALL have parameter CLK_FREQ, default 100_000_000, giving the clock frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 115200, giving the line rate in bit/s.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port rx_i, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port ready_i, input, 1 bit: consumer accepts data_o.
REQ-008 SHALL have port valid_o, output, 1 bit: data_o holds an unconsumed frame.
REQ-009 SHALL have port data_o, output, DATA_WIDTH bits: received frame, LSB = first bit on the line.
REQ-010 SHALL have port frame_err_o, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-011 SHALL have port overrun_o, output, 1 bit: one-cycle pulse when a completed frame is dropped.

Function
REQ-012 SHALL compute CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (truncating) and SHALL fail elaboration if CLKS_PER_BIT < 4.
REQ-013 SHALL pass rx_i through a 2-flop synchronizer (both flops reset to 1) and SHALL use only the synchronized value.
REQ-014 SHALL implement states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-015 In IDLE, a synchronized 0 SHALL move to START and clear the bit-timer.
REQ-016 In START, at timer = CLKS_PER_BIT/2 - 1: sampling 1 SHALL return to IDLE (glitch rejection, no output); sampling 0 SHALL enter DATA with the timer cleared.
REQ-017 In DATA, at each timer = CLKS_PER_BIT - 1 the block SHALL sample, right-shift the bit into the shift register MSB, and clear the timer; after DATA_WIDTH samples it SHALL enter STOP.
REQ-018 In STOP, at timer = CLKS_PER_BIT - 1: sampling 1 SHALL complete the frame and return to IDLE; sampling 0 SHALL pulse frame_err_o, discard the frame and enter WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL return to IDLE only on a synchronized 1 (break/stuck-low tolerance).
REQ-020 On frame completion with valid_o = 0, or with valid_o = 1 and ready_i = 1 in the same cycle, data_o SHALL load the shift register and valid_o SHALL be 1 on the next cycle, with no overrun.
REQ-021 On frame completion with valid_o = 1 and ready_i = 0, the new frame SHALL be dropped, data_o SHALL be unchanged and overrun_o SHALL pulse.
REQ-022 Otherwise, valid_o = 1 with ready_i = 1 SHALL clear valid_o on the next cycle; data_o SHALL stay stable while valid_o = 1.
REQ-023 The latency from the stop-bit sample to valid_o = 1 SHALL be 1 cycle.

Reset
REQ-024 Reset SHALL force: state IDLE, timer 0, shift register 0, both synchronizer flops 1, valid_o 0, data_o 0, frame_err_o 0, overrun_o 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release, reception SHALL resume only on the next falling edge seen in IDLE.

Structure
REQ-026 A shared package uart_pkg SHALL hold the state enum uart_rx_state_e and a function computing CLKS_PER_BIT, for reuse by the transmitter.
REQ-027 The synchronizer SHALL be a sub-module named sync_2ff with a reset-value parameter; all other logic SHALL be flat.

Verification
All scenarios use CLK_FREQ = 1_000_000 and BAUD_RATE = 100_000 (10 clocks per bit).
REQ-028 Frame 0xA5 with ready_i = 1 -> one valid_o pulse with data_o = 0xA5; frame_err_o and overrun_o stay 0.
REQ-029 3-clock low glitch on an idle line -> no valid_o, state back in IDLE; a following frame 0x3C is received correctly.
REQ-030 Frame 0x55 with stop bit held low for 30 clocks -> frame_err_o pulses once, no valid_o; a following frame 0x01 is received as 0x01.
REQ-031 ready_i = 0, frames 0x11 then 0x22 -> data_o = 0x11 with valid_o held, and overrun_o pulses at the end of the 0x22 frame; raising ready_i then clears valid_o.
REQ-032 ready_i asserted in exactly the completion cycle of a second frame 0x77, with 0x66 pending -> 0x66 is accepted, data_o = 0x77, valid_o stays 1, no overrun.
REQ-033 rst_ni pulsed low during bit 4 of a frame -> all outputs 0 during reset; the next full frame 0x9E is received as 0x9E.
